vend_sequencer: RTL and testbench
=================================

// Module: vend_sequencer
// PURPOSE
//  Multi-item vending controller for the Cola Next machine. Accumulates Rs5/Rs10 coins as credit,
//  arbitrates item selection against price and per-item stock, and sequences dispense.
//  Returns change as serial one-cycle Rs5 pulses. Also handles cancel, inactivity timeout and restock.
//  Sits between the coin acceptor / keypad front end and the can-release and change-hopper actuators.
// PARAMETERS
//  PRICE_U     3    item price in Rs5 units (Rs15); all items equal price
//  MAX_CREDIT  6    max credit in Rs5 units (Rs30); must satisfy PRICE_U <= MAX_CREDIT <= 15
//  STOCK_INIT  8    per-item stock loaded at reset/RESTOCK; 1..15
//  TIMEOUT     255  idle cycles in COLLECT before auto-refund; 1..255
// PORTS
//  clk        in   1  clock, rising edge
//  reset      in   1  asynchronous, active-high reset
//  COIN       in   2  01=Rs5, 10=Rs10, 00/11=no coin; one coin per cycle
//  SEL_VALID  in   1  selection strobe, one cycle
//  SEL_ID     in   2  selected item 0..3, sampled with SEL_VALID
//  CANCEL     in   1  refund request, one cycle
//  RESTOCK    in   1  reload all stocks to STOCK_INIT
//  OPEN       out  1  one-cycle can-release pulse
//  ITEM_ID    out  2  item being released; valid while OPEN=1, else 0
//  CHANGE     out  1  one-cycle pulse per Rs5 returned
//  COIN_REJ   out  1  one-cycle pulse: coin in previous cycle not accepted (return chute)
//  SEL_NAK    out  1  one-cycle pulse: selection in previous cycle refused
//  BUSY       out  1  1 in VEND or REFUND
//  CREDIT     out  4  current credit, Rs5 units
//  SOLD_OUT   out  4  bit i = stock[i]==0
// BEHAVIOUR
//  Reset
//  - All outputs 0 except SOLD_OUT=0.
//  - state=IDLE, credit=0, all stocks=STOCK_INIT, timer=0. Reset mid-operation discards credit.
//  State machine (registered; all outputs driven from registers)
//  - IDLE: valid accepted coin -> COLLECT.
//  - COLLECT: coin adds 1 (Rs5) or 2 (Rs10) units; timer clears on any coin, SEL_VALID or CANCEL.
//  - COLLECT -> VEND: SEL_VALID with credit>=PRICE_U and stock[SEL_ID]>0.
//    - Next cycle: OPEN=1, ITEM_ID=SEL_ID, stock[SEL_ID]-=1, credit-=PRICE_U.
//  - COLLECT, refused SEL_VALID (credit<PRICE_U or sold out): SEL_NAK=1 next cycle; stay.
//  - COLLECT, CANCEL or timer reaching TIMEOUT -> REFUND (credit>0 always holds in COLLECT).
//  - VEND, single cycle: -> REFUND if remaining credit>0, else -> IDLE.
//  - REFUND: CHANGE=1 and credit-=1 each cycle; at credit==0 -> IDLE.
//    - Last CHANGE pulse coincides with credit reaching 0.
//  Arithmetic and acceptance
//  - credit is 4-bit unsigned, never exceeds MAX_CREDIT.
//  - Coin whose value would push credit above MAX_CREDIT is rejected: COIN_REJ next cycle, credit unchanged.
//  - Coins arriving in VEND or REFUND are rejected with COIN_REJ.
//  - Stock saturates at 0, never wraps.
//  Simultaneous events (COLLECT)
//  - SEL_VALID + COIN: selection checked against pre-coin credit.
//    - If selection accepted, the coin is rejected; if refused, the coin is processed normally.
//  - CANCEL + COIN: coin processed first (accept/reject), then REFUND of resulting credit.
//  - CANCEL + SEL_VALID: CANCEL wins; selection ignored, no NAK.
//  - CANCEL, SEL_VALID outside COLLECT: ignored, no NAK.
//  - RESTOCK: honoured only in IDLE; ignored elsewhere. A coin in the same IDLE cycle is still accepted.
//  Latency
//  - Accepted select to OPEN: 1 cycle.
//  - Vend with 1 unit change: OPEN at t, CHANGE at t+1, IDLE at t+2.
// TESTING
//  1. Rs5,Rs10, SEL(1) -> CREDIT 1,3; OPEN=1 ITEM_ID=1 next cycle; no CHANGE; stock[1]=7; IDLE.
//  2. Rs10,Rs10, SEL(0) -> OPEN, then 1 CHANGE pulse; CREDIT 4->1->0.
//  3. 3xRs10 then Rs5 -> credit 6, Rs5 COIN_REJ=1; CANCEL -> 6 consecutive CHANGE pulses.
//  4. Vend item 2 eight times; 9th SEL(2) with credit 3 -> SEL_NAK; SOLD_OUT=0100; RESTOCK in IDLE clears it.
//  5. Rs5, then no input for TIMEOUT cycles -> auto REFUND, one CHANGE pulse.
//     Same flow with TIMEOUT-1 cycles then a coin -> no refund.
//  6. Credit 3, SEL(0)+Rs10 same cycle -> OPEN, COIN_REJ.
//     reset asserted during REFUND -> outputs 0 immediately, CREDIT=0.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Front-end / actuator bundle for the vending sequencer.
// Valid/ready: coin, selection, cancel and restock are single-cycle strobes with no back-pressure;
// every response (OPEN, CHANGE, COIN_REJ, SEL_NAK) is a one-cycle pulse the cycle after the cause.
interface vend_sequencer_if;
    logic [1:0] COIN;
    logic       SEL_VALID;
    logic [1:0] SEL_ID;
    logic       CANCEL;
    logic       RESTOCK;
    logic       OPEN;
    logic [1:0] ITEM_ID;
    logic       CHANGE;
    logic       COIN_REJ;
    logic       SEL_NAK;
    logic       BUSY;
    logic [3:0] CREDIT;
    logic [3:0] SOLD_OUT;

    modport master (
        output COIN, SEL_VALID, SEL_ID, CANCEL, RESTOCK,
        input  OPEN, ITEM_ID, CHANGE, COIN_REJ, SEL_NAK, BUSY, CREDIT, SOLD_OUT
    );

    modport slave (
        input  COIN, SEL_VALID, SEL_ID, CANCEL, RESTOCK,
        output OPEN, ITEM_ID, CHANGE, COIN_REJ, SEL_NAK, BUSY, CREDIT, SOLD_OUT
    );
endinterface

// File: rtl/vend_sequencer.sv
// Multi-item vending controller: coin credit, price/stock arbitration, dispense and serial change.
// State encoding on o_dbg_state: 0=IDLE 1=COLLECT 2=VEND 3=REFUND.
module vend_sequencer #(
    parameter int PRICE_U    = 3,
    parameter int MAX_CREDIT = 6,
    parameter int STOCK_INIT = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    vend_sequencer_if.slave      bus,
    output logic [1:0]           o_dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_VEND = 2'd2, S_REFUND = 2'd3} state_t;

    localparam logic [3:0] PRICE4   = 4'(PRICE_U);
    localparam logic [4:0] MAX5     = 5'(MAX_CREDIT);
    localparam logic [3:0] STOCK4   = 4'(STOCK_INIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_nx;
    logic [3:0] r_credit, w_credit_nx;
    logic [7:0] r_timer, w_timer_nx;
    logic [3:0] r_stock [4];
    logic [3:0] w_stock_nx [4];
    logic       r_open, w_open_nx;
    logic [1:0] r_item, w_item_nx;
    logic       r_change, w_change_nx;
    logic       r_coin_rej, w_coin_rej_nx;
    logic       r_sel_nak, w_sel_nak_nx;

    logic [1:0] w_coin_val;
    logic       w_coin_hit;
    logic [4:0] w_sum;
    logic       w_coin_fits;
    logic [3:0] w_credit_coin;
    logic       w_sel_ok;

    assign w_coin_val    = (bus.COIN == 2'b01) ? 2'd1 : (bus.COIN == 2'b10) ? 2'd2 : 2'd0;
    assign w_coin_hit    = (w_coin_val != 2'd0);
    assign w_sum         = {1'b0, r_credit} + {3'b000, w_coin_val};
    assign w_coin_fits   = (w_sum <= MAX5);
    assign w_credit_coin = (w_coin_hit && w_coin_fits) ? w_sum[3:0] : r_credit;
    // Selection is judged on the credit held before any same-cycle coin.
    assign w_sel_ok      = bus.SEL_VALID && (r_credit >= PRICE4) && (r_stock[bus.SEL_ID] != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_credit   <= 4'd0;
            r_timer    <= 8'd0;
            for (int i = 0; i < 4; i++) r_stock[i] <= STOCK4;
            r_open     <= 1'b0;
            r_item     <= 2'd0;
            r_change   <= 1'b0;
            r_coin_rej <= 1'b0;
            r_sel_nak  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_credit   <= w_credit_nx;
            r_timer    <= w_timer_nx;
            for (int i = 0; i < 4; i++) r_stock[i] <= w_stock_nx[i];
            r_open     <= w_open_nx;
            r_item     <= w_item_nx;
            r_change   <= w_change_nx;
            r_coin_rej <= w_coin_rej_nx;
            r_sel_nak  <= w_sel_nak_nx;
        end
    end

    // Each change pulse is issued on the same edge that decrements credit, so the last
    // pulse is visible in the cycle where CREDIT first reads 0.
    always_comb begin
        w_state_nx    = r_state;
        w_credit_nx   = r_credit;
        w_timer_nx    = 8'd0;
        w_stock_nx    = r_stock;
        w_open_nx     = 1'b0;
        w_item_nx     = 2'd0;
        w_change_nx   = 1'b0;
        w_coin_rej_nx = 1'b0;
        w_sel_nak_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.RESTOCK) begin
                    for (int i = 0; i < 4; i++) w_stock_nx[i] = STOCK4;
                end
                if (w_coin_hit) begin
                    w_credit_nx = {2'b00, w_coin_val};
                    w_state_nx  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.CANCEL) begin
                    w_coin_rej_nx = w_coin_hit && !w_coin_fits;
                    w_change_nx   = 1'b1;
                    w_credit_nx   = w_credit_coin - 4'd1;
                    w_state_nx    = S_REFUND;
                end else if (w_sel_ok) begin
                    w_coin_rej_nx              = w_coin_hit;
                    w_open_nx                  = 1'b1;
                    w_item_nx                  = bus.SEL_ID;
                    w_stock_nx[bus.SEL_ID]     = r_stock[bus.SEL_ID] - 4'd1;
                    w_credit_nx                = r_credit - PRICE4;
                    w_state_nx                 = S_VEND;
                end else begin
                    w_sel_nak_nx  = bus.SEL_VALID;
                    w_coin_rej_nx = w_coin_hit && !w_coin_fits;
                    w_credit_nx   = w_credit_coin;
                    if (!w_coin_hit && !bus.SEL_VALID) begin
                        if (r_timer == TMO_LAST) begin
                            w_change_nx = 1'b1;
                            w_credit_nx = r_credit - 4'd1;
                            w_state_nx  = S_REFUND;
                        end else begin
                            w_timer_nx = r_timer + 8'd1;
                        end
                    end
                end
            end
            S_VEND, S_REFUND: begin
                w_coin_rej_nx = w_coin_hit;
                if (r_credit != 4'd0) begin
                    w_change_nx = 1'b1;
                    w_credit_nx = r_credit - 4'd1;
                    w_state_nx  = S_REFUND;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.OPEN     = r_open;
        bus.ITEM_ID  = r_item;
        bus.CHANGE   = r_change;
        bus.COIN_REJ = r_coin_rej;
        bus.SEL_NAK  = r_sel_nak;
        bus.BUSY     = (r_state == S_VEND) || (r_state == S_REFUND);
        bus.CREDIT   = r_credit;
        bus.SOLD_OUT = 4'd0;
        for (int i = 0; i < 4; i++) bus.SOLD_OUT[i] = (r_stock[i] == 4'd0);
        o_dbg_state  = r_state;
    end
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with hand-computed expectations.
module tb_vend_sequencer;
    localparam int TMO = 255;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_COLLECT = 2'd1, ST_VEND = 2'd2, ST_REFUND = 2'd3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    vend_sequencer_if bus();

    vend_sequencer #(.PRICE_U(3), .MAX_CREDIT(6), .STOCK_INIT(8), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] coin, input logic sv, input logic [1:0] sid,
                         input logic cancel, input logic restock);
        bus.COIN = coin; bus.SEL_VALID = sv; bus.SEL_ID = sid;
        bus.CANCEL = cancel; bus.RESTOCK = restock;
        tick();
        bus.COIN = 2'b00; bus.SEL_VALID = 1'b0; bus.SEL_ID = 2'd0;
        bus.CANCEL = 1'b0; bus.RESTOCK = 1'b0;
    endtask

    // Runs out a refund, checking each CHANGE pulse against queued credit values.
    task automatic drain_refund(input string tag);
        while (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check_eq({tag, "_chg"}, {31'd0, bus.CHANGE}, 32'd1);
            check_eq({tag, "_cr"}, {28'd0, bus.CREDIT}, {28'd0, e});
            tick();
        end
        check_eq({tag, "_end_chg"}, {31'd0, bus.CHANGE}, 32'd0);
        check_eq({tag, "_end_st"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
    endtask

    initial begin
        bus.COIN = 2'b00; bus.SEL_VALID = 1'b0; bus.SEL_ID = 2'd0;
        bus.CANCEL = 1'b0; bus.RESTOCK = 1'b0;
        repeat (2) tick();
        check_eq("rst_open", {31'd0, bus.OPEN}, 32'd0);
        check_eq("rst_credit", {28'd0, bus.CREDIT}, 32'd0);
        check_eq("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check_eq("rst_soldout", {28'd0, bus.SOLD_OUT}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: Rs5 + Rs10, select item 1, exact price
        drive(2'b01, 0, 0, 0, 0);
        check_eq("t1_cr1", {28'd0, bus.CREDIT}, 32'd1);
        check_eq("t1_st", {30'd0, dbg_state}, {30'd0, ST_COLLECT});
        drive(2'b10, 0, 0, 0, 0);
        check_eq("t1_cr3", {28'd0, bus.CREDIT}, 32'd3);
        drive(2'b00, 1, 2'd1, 0, 0);
        check_eq("t1_open", {31'd0, bus.OPEN}, 32'd1);
        check_eq("t1_item", {30'd0, bus.ITEM_ID}, 32'd1);
        check_eq("t1_cr0", {28'd0, bus.CREDIT}, 32'd0);
        check_eq("t1_busy", {31'd0, bus.BUSY}, 32'd1);
        tick();
        check_eq("t1_open_off", {31'd0, bus.OPEN}, 32'd0);
        check_eq("t1_item_off", {30'd0, bus.ITEM_ID}, 32'd0);
        check_eq("t1_nochg", {31'd0, bus.CHANGE}, 32'd0);
        check_eq("t1_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // 2: 2x Rs10, select item 0, one unit change
        drive(2'b10, 0, 0, 0, 0);
        drive(2'b10, 0, 0, 0, 0);
        check_eq("t2_cr4", {28'd0, bus.CREDIT}, 32'd4);
        drive(2'b00, 1, 2'd0, 0, 0);
        check_eq("t2_open", {31'd0, bus.OPEN}, 32'd1);
        check_eq("t2_cr1", {28'd0, bus.CREDIT}, 32'd1);
        tick();
        check_eq("t2_chg", {31'd0, bus.CHANGE}, 32'd1);
        check_eq("t2_cr0", {28'd0, bus.CREDIT}, 32'd0);
        check_eq("t2_busy", {31'd0, bus.BUSY}, 32'd1);
        tick();
        check_eq("t2_chg_off", {31'd0, bus.CHANGE}, 32'd0);
        check_eq("t2_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});

        // 3: fill to max credit, overflow coin rejected, cancel returns 6 pulses
        repeat (3) drive(2'b10, 0, 0, 0, 0);
        check_eq("t3_cr6", {28'd0, bus.CREDIT}, 32'd6);
        drive(2'b01, 0, 0, 0, 0);
        check_eq("t3_rej", {31'd0, bus.COIN_REJ}, 32'd1);
        check_eq("t3_cr6b", {28'd0, bus.CREDIT}, 32'd6);
        drive(2'b00, 0, 0, 1, 0);
        for (int i = 5; i >= 0; i--) exp_q.push_back(4'(i));
        drain_refund("t3");

        // 4: exhaust item 2, refused select, restock
        for (int k = 0; k < 8; k++) begin
            drive(2'b10, 0, 0, 0, 0);
            drive(2'b01, 0, 0, 0, 0);
            drive(2'b00, 1, 2'd2, 0, 0);
            check_eq("t4_open", {31'd0, bus.OPEN}, 32'd1);
            tick();
        end
        check_eq("t4_soldout", {28'd0, bus.SOLD_OUT}, 32'b0100);
        drive(2'b10, 0, 0, 0, 0);
        drive(2'b01, 0, 0, 0, 0);
        drive(2'b00, 1, 2'd2, 0, 0);
        check_eq("t4_nak", {31'd0, bus.SEL_NAK}, 32'd1);
        check_eq("t4_noopen", {31'd0, bus.OPEN}, 32'd0);
        check_eq("t4_cr3", {28'd0, bus.CREDIT}, 32'd3);
        check_eq("t4_st", {30'd0, dbg_state}, {30'd0, ST_COLLECT});
        drive(2'b00, 0, 0, 1, 0);
        for (int i = 2; i >= 0; i--) exp_q.push_back(4'(i));
        drain_refund("t4");
        drive(2'b00, 0, 0, 0, 1);
        check_eq("t4_restock", {28'd0, bus.SOLD_OUT}, 32'd0);

        // 5: inactivity timeout, then the one-cycle-short case
        drive(2'b01, 0, 0, 0, 0);
        repeat (TMO - 1) tick();
        check_eq("t5_pre_st", {30'd0, dbg_state}, {30'd0, ST_COLLECT});
        check_eq("t5_pre_chg", {31'd0, bus.CHANGE}, 32'd0);
        tick();
        exp_q.push_back(4'd0);
        drain_refund("t5");
        drive(2'b01, 0, 0, 0, 0);
        repeat (TMO - 1) tick();
        drive(2'b01, 0, 0, 0, 0);
        check_eq("t5b_cr2", {28'd0, bus.CREDIT}, 32'd2);
        tick();
        check_eq("t5b_nochg", {31'd0, bus.CHANGE}, 32'd0);
        check_eq("t5b_st", {30'd0, dbg_state}, {30'd0, ST_COLLECT});
        // cancel with a simultaneous select: cancel wins, no NAK
        drive(2'b00, 1, 2'd0, 1, 0);
        check_eq("t5b_nonak", {31'd0, bus.SEL_NAK}, 32'd0);
        check_eq("t5b_noopen", {31'd0, bus.OPEN}, 32'd0);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd0);
        drain_refund("t5b");

        // 6: select with a same-cycle coin, then reset during refund
        drive(2'b10, 0, 0, 0, 0);
        drive(2'b01, 0, 0, 0, 0);
        drive(2'b10, 1, 2'd0, 0, 0);
        check_eq("t6_open", {31'd0, bus.OPEN}, 32'd1);
        check_eq("t6_rej", {31'd0, bus.COIN_REJ}, 32'd1);
        check_eq("t6_cr0", {28'd0, bus.CREDIT}, 32'd0);
        tick();
        check_eq("t6_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        drive(2'b10, 0, 0, 0, 0);
        drive(2'b10, 0, 0, 0, 0);
        drive(2'b00, 0, 0, 1, 0);
        check_eq("t6_ref_chg", {31'd0, bus.CHANGE}, 32'd1);
        check_eq("t6_ref_cr", {28'd0, bus.CREDIT}, 32'd3);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_chg", {31'd0, bus.CHANGE}, 32'd0);
        check_eq("t6_rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check_eq("t6_rst_cr", {28'd0, bus.CREDIT}, 32'd0);
        check_eq("t6_rst_st", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
